fetch_inst_select: RTL and testbench
====================================

// Module: fetch_inst_select
// PURPOSE
//  Registered successor to the fetch-stage instruction-word mux. It arbitrates between the
//  instruction-memory word and a queue of hazard-unit injected words (bubbles, micro-ops).
//  Injected words take priority; the fetch PC advances only when a memory word is consumed.
//  Sits between instruction memory and the IF/ID pipeline register; honours decode stall and flush.
// PARAMETERS
//  WORD_W     32            instruction word width
//  INJ_DEPTH  4             injection FIFO depth, power of two, >= 2
//  NOP_WORD   32'h00000000  word driven when the output is invalid or after flush/reset
// PORTS
//  clk            in   1                      rising-edge clock
//  rst            in   1                      synchronous, active-high reset
//  mem_inst_word  in   WORD_W                 word from instruction memory
//  mem_valid      in   1                      mem_inst_word is valid this cycle
//  inj_word       in   WORD_W                 hazard-unit word to enqueue
//  inj_push       in   1                      enqueue inj_word
//  inj_full       out  1                      FIFO holds INJ_DEPTH entries (combinational from count)
//  inj_count      out  $clog2(INJ_DEPTH)+1    current FIFO occupancy
//  inj_overflow   out  1                      sticky: a push was dropped
//  stall          in   1                      decode stall: hold output
//  flush          in   1                      discard queued and held words
//  mem_consume    out  1                      combinational: memory word taken this cycle; PC advances
//  inst_word_out  out  WORD_W                 registered instruction word to decode
//  inst_valid_out out  1                      inst_word_out is valid
//  inst_sel_out   out  1                      0 = from memory, 1 = injected
// BEHAVIOUR
//  - Reset: inst_word_out=NOP_WORD; inst_valid_out=0; inst_sel_out=0; FIFO empty (count 0);
//    inj_overflow=0. mem_consume=0 while rst is high.
//  - Selection latency is 1 cycle; the output register updates on each clk edge per the priority below.
//  - Priority per edge: rst > flush > stall > FIFO non-empty > mem_valid > idle.
//  - flush: output<=NOP_WORD, valid<=0, sel<=0. FIFO is cleared and inj_overflow is cleared.
//    A push in the same cycle is dropped and does not set overflow. mem_consume=0.
//  - stall (no flush): output, valid and sel are held. No pop occurs. mem_consume=0. Pushes are still accepted.
//  - FIFO non-empty: output<=head, valid<=1, sel<=1. The head is popped and mem_consume=0,
//    whatever mem_valid is.
//  - FIFO empty and mem_valid: output<=mem_inst_word, valid<=1, sel<=0, mem_consume=1.
//  - Otherwise: output<=NOP_WORD, valid<=0, sel<=0.
//  - There is no bypass. A word pushed into an empty FIFO is selectable on the next cycle, not the same cycle.
//  - Push while full: accepted only if a pop occurs the same cycle (count unchanged).
//    Otherwise the push is dropped and inj_overflow<=1 (sticky until rst or flush).
//  - Simultaneous push and pop when not full: count is unchanged and order is preserved (FIFO).
//  - Read/write pointers are $clog2(INJ_DEPTH) bits and wrap modulo INJ_DEPTH.
//    Count is kept separately to tell full from empty.
//  - inj_full and inj_count reflect registered state: pre-edge values, no same-cycle push/pop look-ahead.
//  - Reset asserted mid-stream discards all queued words with no partial output.
// STRUCTURE
//  - Shared header fetch_defs.vh: FETCH_SEL_MEM=1'b0, FETCH_SEL_INJ=1'b1, default FETCH_NOP_WORD.
//  - Sub-module inj_fifo: synchronous FIFO, params WIDTH/DEPTH.
//    Ports: clk, rst, clr, push, pop, din, dout, full, empty, count, drop.
//    Head is visible combinationally on dout.
//  - Top level: the priority logic, the output register, and mem_consume/overflow generation.
// TESTING
//  1. Reset: rst=1 for 2 cycles with mem_valid=1.
//     -> valid=0, word=0, count=0, overflow=0, mem_consume=0 throughout.
//  2. Pass-through: FIFO empty, mem words 0xA0000001/0xA0000002 with mem_valid=1.
//     -> outputs 1 cycle later in order, sel=0, mem_consume=1 each cycle.
//  3. Priority: push 0xDEAD0001 and 0xDEAD0002 while mem_valid=1 with 0x11111111.
//     -> the next two outputs are the injected words with sel=1 and mem_consume=0,
//        then 0x11111111 with sel=0.
//  4. Full/overflow: DEPTH=4, stall=1, push 5 words.
//     -> inj_full=1 after 4 pushes, the 5th is dropped, overflow=1.
//     Release stall -> exactly the 4 words drain in FIFO order.
//  5. Stall hold: output 0xCAFEF00D valid, stall=1 for 3 cycles with mem_valid=1.
//     -> output held, mem_consume=0.
//     Release -> next word is from the FIFO head or memory.
//  6. Flush with push: 2 queued words plus push and flush in the same cycle.
//     -> next cycle valid=0, word=NOP_WORD, count=0, overflow=0. Subsequent memory words flow normally.

Source files
------------

// File: rtl/fetch_inst_select_pkg.sv
// fetch_inst_select_pkg: shared select codes, default NOP word and per-edge action type
package fetch_inst_select_pkg;
   localparam logic        FETCH_SEL_MEM  = 1'b0;
   localparam logic        FETCH_SEL_INJ  = 1'b1;
   localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;
   typedef enum logic [2:0] {ACT_FLUSH, ACT_STALL, ACT_INJ, ACT_MEM, ACT_IDLE} act_e;
endpackage

// File: rtl/fetch_inst_select_inj.sv
// inj_fifo: synchronous FIFO with separate occupancy count, head visible on dout
module inj_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic             do_pop, do_push;
   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop & ~empty & ~clr;
   // a full queue still takes a push when the head leaves in the same cycle
   assign do_push = push & ~clr & (~full | do_pop);
   assign drop    = push & ~clr & ~do_push;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/fetch_inst_select.sv
// fetch_inst_select: registered arbitration between memory words and injected hazard words
module fetch_inst_select
   import fetch_inst_select_pkg::*;
#(
   parameter int                WORD_W    = 32,
   parameter int                INJ_DEPTH = 4,
   parameter logic [WORD_W-1:0] NOP_WORD  = WORD_W'(FETCH_NOP_WORD)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WORD_W-1:0]          mem_inst_word,
   input  logic                       mem_valid,
   input  logic [WORD_W-1:0]          inj_word,
   input  logic                       inj_push,
   output logic                       inj_full,
   output logic [$clog2(INJ_DEPTH):0] inj_count,
   output logic                       inj_overflow,
   input  logic                       stall,
   input  logic                       flush,
   output logic                       mem_consume,
   output logic [WORD_W-1:0]          inst_word_out,
   output logic                       inst_valid_out,
   output logic                       inst_sel_out
);
   logic [WORD_W-1:0] head;
   logic              fifo_empty, fifo_drop;
   act_e              act;
   inj_fifo #(.WIDTH(WORD_W), .DEPTH(INJ_DEPTH)) u_inj (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (inj_push),
      .pop   (act == ACT_INJ),
      .din   (inj_word),
      .dout  (head),
      .full  (inj_full),
      .empty (fifo_empty),
      .count (inj_count),
      .drop  (fifo_drop)
   );
   always_comb begin
      act = flush ? ACT_FLUSH : stall ? ACT_STALL : !fifo_empty ? ACT_INJ : mem_valid ? ACT_MEM : ACT_IDLE;
      mem_consume = ~rst & (act == ACT_MEM);
   end
   always_ff @(posedge clk) begin
      if (rst || act == ACT_FLUSH || act == ACT_IDLE) begin
         inst_word_out  <= NOP_WORD;
         inst_valid_out <= 1'b0;
         inst_sel_out   <= FETCH_SEL_MEM;
      end else if (act == ACT_INJ) begin
         inst_word_out  <= head;
         inst_valid_out <= 1'b1;
         inst_sel_out   <= FETCH_SEL_INJ;
      end else if (act == ACT_MEM) begin
         inst_word_out  <= mem_inst_word;
         inst_valid_out <= 1'b1;
         inst_sel_out   <= FETCH_SEL_MEM;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || flush) inj_overflow <= 1'b0;
      else if (fifo_drop) inj_overflow <= 1'b1;
   end
endmodule

// File: tb/tb_fetch_inst_select.sv
// tb_fetch_inst_select: directed scenarios for the fetch instruction selector
module tb_fetch_inst_select;
   logic        clk = 1'b0;
   logic        rst, mem_valid, inj_push, stall, flush;
   logic [31:0] mem_inst_word, inj_word;
   logic        inj_full, inj_overflow, mem_consume, inst_valid_out, inst_sel_out;
   logic [2:0]  inj_count;
   logic [31:0] inst_word_out;
   int          total = 0, passed = 0;

   fetch_inst_select #(.WORD_W(32), .INJ_DEPTH(4), .NOP_WORD(32'h0)) dut (
      .clk(clk), .rst(rst), .mem_inst_word(mem_inst_word), .mem_valid(mem_valid),
      .inj_word(inj_word), .inj_push(inj_push), .inj_full(inj_full), .inj_count(inj_count),
      .inj_overflow(inj_overflow), .stall(stall), .flush(flush), .mem_consume(mem_consume),
      .inst_word_out(inst_word_out), .inst_valid_out(inst_valid_out), .inst_sel_out(inst_sel_out)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      rst = 1; mem_valid = 1; mem_inst_word = 32'h12345678; inj_push = 0; inj_word = 0; stall = 0; flush = 0;
      for (int i = 0; i < 2; i++) begin
         #3;
         total++; if (mem_consume !== 1'b0) $display("FAIL reset_consume: got %b want 0", mem_consume); else passed++;
         @(posedge clk); #1;
         total++; if (inst_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid_out); else passed++;
         total++; if (inst_word_out !== 32'h0) $display("FAIL reset_word: got %h want 0", inst_word_out); else passed++;
         total++; if (inj_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", inj_count); else passed++;
         total++; if (inj_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", inj_overflow); else passed++;
      end
      rst = 0;
   endtask

   task automatic test_pass_through;
      logic [31:0] words [2] = '{32'hA000_0001, 32'hA000_0002};
      mem_valid = 1;
      for (int i = 0; i < 2; i++) begin
         mem_inst_word = words[i];
         #3;
         total++; if (mem_consume !== 1'b1) $display("FAIL pass_consume%0d: got %b want 1", i, mem_consume); else passed++;
         @(posedge clk); #1;
         total++; if (inst_word_out !== words[i]) $display("FAIL pass_word%0d: got %h want %h", i, inst_word_out, words[i]); else passed++;
         total++; if ({inst_valid_out, inst_sel_out} !== 2'b10) $display("FAIL pass_vs%0d: got %b want 10", i, {inst_valid_out, inst_sel_out}); else passed++;
      end
      mem_valid = 0;
      @(posedge clk); #1;
      total++; if ({inst_valid_out, inst_word_out} !== 33'h0) $display("FAIL pass_idle: got %b/%h want 0/0", inst_valid_out, inst_word_out); else passed++;
   endtask

   task automatic test_priority;
      inj_push = 1; inj_word = 32'hDEAD_0001; mem_valid = 0;
      @(posedge clk); #1;
      inj_word = 32'hDEAD_0002; mem_valid = 1; mem_inst_word = 32'h1111_1111;
      #3;
      total++; if (mem_consume !== 1'b0) $display("FAIL prio_consume0: got %b want 0", mem_consume); else passed++;
      @(posedge clk); #1;
      inj_push = 0;
      total++; if ({inst_sel_out, inst_word_out} !== {1'b1, 32'hDEAD_0001}) $display("FAIL prio_word0: got %b/%h want 1/dead0001", inst_sel_out, inst_word_out); else passed++;
      total++; if (inj_count !== 3'd1) $display("FAIL prio_count: got %0d want 1", inj_count); else passed++;
      #3;
      total++; if (mem_consume !== 1'b0) $display("FAIL prio_consume1: got %b want 0", mem_consume); else passed++;
      @(posedge clk); #1;
      total++; if ({inst_sel_out, inst_word_out} !== {1'b1, 32'hDEAD_0002}) $display("FAIL prio_word1: got %b/%h want 1/dead0002", inst_sel_out, inst_word_out); else passed++;
      #3;
      total++; if (mem_consume !== 1'b1) $display("FAIL prio_consume2: got %b want 1", mem_consume); else passed++;
      @(posedge clk); #1;
      total++; if ({inst_valid_out, inst_sel_out, inst_word_out} !== {2'b10, 32'h1111_1111}) $display("FAIL prio_mem: got %b%b/%h want 10/11111111", inst_valid_out, inst_sel_out, inst_word_out); else passed++;
      mem_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_overflow;
      logic [31:0] exp [5] = '{32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 32'hB000_0005, 32'hB000_0007};
      stall = 1; mem_valid = 0;
      for (int i = 0; i < 5; i++) begin
         inj_push = 1; inj_word = 32'hB000_0001 + 32'(i) + 32'd1;
         #3;
         total++; if (inj_count !== 3'(i < 4 ? i : 4)) $display("FAIL ovf_count%0d: got %0d want %0d", i, inj_count, i < 4 ? i : 4); else passed++;
         total++; if (inj_full !== (i == 4)) $display("FAIL ovf_full%0d: got %b want %b", i, inj_full, i == 4); else passed++;
         @(posedge clk); #1;
      end
      inj_push = 0;
      total++; if (inj_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", inj_overflow); else passed++;
      total++; if (inst_valid_out !== 1'b0) $display("FAIL ovf_hold: got %b want 0", inst_valid_out); else passed++;
      stall = 0; mem_valid = 1; mem_inst_word = 32'h2222_2222;
      for (int i = 0; i < 5; i++) begin
         inj_push = (i == 0); inj_word = 32'hB000_0007;
         #3;
         total++; if (mem_consume !== 1'b0) $display("FAIL drain_consume%0d: got %b want 0", i, mem_consume); else passed++;
         @(posedge clk); #1;
         inj_push = 0;
         total++; if ({inst_sel_out, inst_word_out} !== {1'b1, exp[i]}) $display("FAIL drain_word%0d: got %b/%h want 1/%h", i, inst_sel_out, inst_word_out, exp[i]); else passed++;
         if (i == 0) begin
            total++; if (inj_count !== 3'd4) $display("FAIL drain_pushpop_count: got %0d want 4", inj_count); else passed++;
         end
      end
      #3;
      total++; if (mem_consume !== 1'b1) $display("FAIL drain_mem_consume: got %b want 1", mem_consume); else passed++;
      @(posedge clk); #1;
      total++; if ({inst_sel_out, inst_word_out} !== {1'b0, 32'h2222_2222}) $display("FAIL drain_mem: got %b/%h want 0/22222222", inst_sel_out, inst_word_out); else passed++;
      total++; if (inj_overflow !== 1'b1) $display("FAIL drain_sticky: got %b want 1", inj_overflow); else passed++;
   endtask

   task automatic test_stall;
      mem_valid = 1; mem_inst_word = 32'hCAFE_F00D;
      @(posedge clk); #1;
      stall = 1; mem_inst_word = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
         inj_push = (i == 1); inj_word = 32'hD000_0001;
         #3;
         total++; if (mem_consume !== 1'b0) $display("FAIL stall_consume%0d: got %b want 0", i, mem_consume); else passed++;
         @(posedge clk); #1;
         inj_push = 0;
         total++; if ({inst_valid_out, inst_sel_out, inst_word_out} !== {2'b10, 32'hCAFE_F00D}) $display("FAIL stall_hold%0d: got %b%b/%h want 10/cafef00d", i, inst_valid_out, inst_sel_out, inst_word_out); else passed++;
      end
      total++; if (inj_count !== 3'd1) $display("FAIL stall_push_count: got %0d want 1", inj_count); else passed++;
      stall = 0;
      @(posedge clk); #1;
      total++; if ({inst_sel_out, inst_word_out} !== {1'b1, 32'hD000_0001}) $display("FAIL stall_release_inj: got %b/%h want 1/d0000001", inst_sel_out, inst_word_out); else passed++;
      @(posedge clk); #1;
      total++; if ({inst_sel_out, inst_word_out} !== {1'b0, 32'h3333_3333}) $display("FAIL stall_release_mem: got %b/%h want 0/33333333", inst_sel_out, inst_word_out); else passed++;
   endtask

   task automatic test_flush;
      stall = 1; mem_valid = 0; inj_push = 1;
      inj_word = 32'hE000_0001; @(posedge clk); #1;
      inj_word = 32'hE000_0002; @(posedge clk); #1;
      total++; if (inj_count !== 3'd2) $display("FAIL flush_pre_count: got %0d want 2", inj_count); else passed++;
      stall = 0; flush = 1; inj_word = 32'hE000_0003; mem_valid = 1; mem_inst_word = 32'h4444_4444;
      #3;
      total++; if (mem_consume !== 1'b0) $display("FAIL flush_consume: got %b want 0", mem_consume); else passed++;
      @(posedge clk); #1;
      flush = 0; inj_push = 0;
      total++; if ({inst_valid_out, inst_sel_out, inst_word_out} !== 34'h0) $display("FAIL flush_out: got %b%b/%h want 00/0", inst_valid_out, inst_sel_out, inst_word_out); else passed++;
      total++; if (inj_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", inj_count); else passed++;
      total++; if (inj_overflow !== 1'b0) $display("FAIL flush_overflow: got %b want 0", inj_overflow); else passed++;
      for (int i = 0; i < 2; i++) begin
         mem_inst_word = 32'h4444_4444 + 32'(i);
         #3;
         total++; if (mem_consume !== 1'b1) $display("FAIL post_flush_consume%0d: got %b want 1", i, mem_consume); else passed++;
         @(posedge clk); #1;
         total++; if ({inst_sel_out, inst_word_out} !== {1'b0, 32'h4444_4444 + 32'(i)}) $display("FAIL post_flush_word%0d: got %b/%h want 0/%h", i, inst_sel_out, inst_word_out, 32'h4444_4444 + 32'(i)); else passed++;
      end
   endtask

   task automatic test_reset_mid;
      stall = 1; mem_valid = 0; inj_push = 1;
      inj_word = 32'hF000_0001; @(posedge clk); #1;
      inj_word = 32'hF000_0002; @(posedge clk); #1;
      inj_push = 0; stall = 0; rst = 1; mem_valid = 1;
      @(posedge clk); #1;
      total++; if ({inj_count, inst_valid_out} !== 4'b0) $display("FAIL midrst: got count %0d valid %b want 0/0", inj_count, inst_valid_out); else passed++;
      rst = 0; mem_valid = 0;
      @(posedge clk); #1;
      total++; if (inst_valid_out !== 1'b0) $display("FAIL midrst_leftover: got %b/%h want 0", inst_valid_out, inst_word_out); else passed++;
   endtask

   initial begin
      test_reset;
      test_pass_through;
      test_priority;
      test_overflow;
      test_stall;
      test_flush;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
